// File: rtl/wb_port_sched.sv
// wb_port_sched: owns the two register-file write ports. It resolves
// same-destination collisions between the two writeback lanes in program
// order. It queues long-latency results in a small FIFO and slots them
// into idle ports, or merges them beneath a lane writing the same
// register. A starvation counter forces a one-cycle writeback stall so
// that the FIFO head is guaranteed to drain.
//
// Handshake: a long-latency result transfers on a rising clk edge where
// lr_valid && lr_ready. lr_ready depends only on FIFO occupancy, never on
// lr_valid. Lane writes take effect at the edge where they are presented
// unless wb_stall is high, in which case the pipeline re-presents them.
module wb_port_sched #(
  parameter int LR_DEPTH   = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            ws0_valid,
  input  logic [3:0]                      ws0_rf_we,
  input  logic [4:0]                      ws0_dest,
  input  logic [31:0]                     ws0_wdata,
  input  logic                            ws1_valid,
  input  logic [3:0]                      ws1_rf_we,
  input  logic [4:0]                      ws1_dest,
  input  logic [31:0]                     ws1_wdata,
  input  logic                            ws_first,
  input  logic                            lr_valid,
  output logic                            lr_ready,
  input  logic [3:0]                      lr_we,
  input  logic [4:0]                      lr_dest,
  input  logic [31:0]                     lr_wdata,
  output logic [3:0]                      rf_we0,
  output logic [4:0]                      rf_waddr0,
  output logic [31:0]                     rf_wdata0,
  output logic [3:0]                      rf_we1,
  output logic [4:0]                      rf_waddr1,
  output logic [31:0]                     rf_wdata1,
  output logic                            wb_stall,
  output logic [$clog2(LR_DEPTH+1)-1:0]   lr_count
);

  localparam int AW = $clog2(LR_DEPTH);
  localparam int CW = $clog2(LR_DEPTH+1);
  localparam int SW = $clog2(STARVE_MAX+1);

  logic [3:0]    q_we   [LR_DEPTH];
  logic [4:0]    q_dest [LR_DEPTH];
  logic [31:0]   q_data [LR_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;

  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  logic [3:0]    e0, e1;
  logic [3:0]    o_we, y_we;
  logic [4:0]    o_dest, y_dest;
  logic [31:0]   o_data, y_data;
  logic [3:0]    h_we;
  logic [4:0]    h_dest;
  logic [31:0]   h_data;
  logic          p0_used, p1_used;
  logic [3:0]    p0_we, p1_we;
  logic [4:0]    p0_addr, p1_addr;
  logic [31:0]   p0_data, p1_data;

  // Byte-wise overlay: bytes of top where its enable is set, bot elsewhere.
  function automatic logic [31:0] overlay(input logic [3:0] top_we,
                                          input logic [31:0] top_d,
                                          input logic [31:0] bot_d);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[b*8 +: 8] = top_we[b] ? top_d[b*8 +: 8] : bot_d[b*8 +: 8];
    end
    return r;
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(LR_DEPTH));
  assign lr_ready = !full;
  assign push     = lr_valid && lr_ready;
  assign wb_stall = (starve_cnt == SW'(STARVE_MAX));
  assign lr_count = count;

  assign h_dest = q_dest[rd_ptr];
  assign h_data = q_data[rd_ptr];
  assign h_we   = (h_dest == 5'd0) ? 4'd0 : q_we[rd_ptr];

  // Port assignment: lanes in program order first, then the FIFO head.
  always_comb begin
    e0      = ws0_valid ? ws0_rf_we : 4'd0;
    e1      = ws1_valid ? ws1_rf_we : 4'd0;
    if (ws0_dest == 5'd0 || wb_stall) e0 = 4'd0;
    if (ws1_dest == 5'd0 || wb_stall) e1 = 4'd0;

    if (ws_first) begin
      o_we = e0; o_dest = ws0_dest; o_data = ws0_wdata;
      y_we = e1; y_dest = ws1_dest; y_data = ws1_wdata;
    end else begin
      o_we = e1; o_dest = ws1_dest; o_data = ws1_wdata;
      y_we = e0; y_dest = ws0_dest; y_data = ws0_wdata;
    end

    p0_used = 1'b0; p0_we = 4'd0; p0_addr = 5'd0; p0_data = 32'd0;
    p1_used = 1'b0; p1_we = 4'd0; p1_addr = 5'd0; p1_data = 32'd0;
    pop     = 1'b0;

    if (o_we != 4'd0 && y_we != 4'd0 && o_dest == y_dest) begin
      p0_used = 1'b1;
      p0_we   = o_we | y_we;
      p0_addr = o_dest;
      p0_data = overlay(y_we, y_data, o_data);
    end else if (o_we != 4'd0 && y_we != 4'd0) begin
      p0_used = 1'b1; p0_we = o_we; p0_addr = o_dest; p0_data = o_data;
      p1_used = 1'b1; p1_we = y_we; p1_addr = y_dest; p1_data = y_data;
    end else if (o_we != 4'd0) begin
      p0_used = 1'b1; p0_we = o_we; p0_addr = o_dest; p0_data = o_data;
    end else if (y_we != 4'd0) begin
      p0_used = 1'b1; p0_we = y_we; p0_addr = y_dest; p0_data = y_data;
    end

    // The head is older than every lane, so lane bytes always win a merge.
    if (!empty) begin
      if (p0_used && p0_addr == h_dest) begin
        pop     = 1'b1;
        p0_data = overlay(p0_we, p0_data, h_data);
        p0_we   = p0_we | h_we;
      end else if (p1_used && p1_addr == h_dest) begin
        pop     = 1'b1;
        p1_data = overlay(p1_we, p1_data, h_data);
        p1_we   = p1_we | h_we;
      end else if (!p0_used) begin
        pop = 1'b1; p0_we = h_we; p0_addr = h_dest; p0_data = h_data;
      end else if (!p1_used) begin
        pop = 1'b1; p1_we = h_we; p1_addr = h_dest; p1_data = h_data;
      end
    end
  end

  // Nothing reaches the register file on an edge where reset is sampled.
  assign rf_we0    = reset ? 4'd0 : p0_we;
  assign rf_waddr0 = p0_addr;
  assign rf_wdata0 = p0_data;
  assign rf_we1    = reset ? 4'd0 : p1_we;
  assign rf_waddr1 = p1_addr;
  assign rf_wdata1 = p1_data;

  // FIFO storage: written on an accepted push, never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      q_we[wr_ptr]   <= lr_we;
      q_dest[wr_ptr] <= lr_dest;
      q_data[wr_ptr] <= lr_wdata;
    end
  end

  // FIFO pointers/occupancy and the starvation counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (empty || pop) begin
        starve_cnt <= '0;
      end else if (starve_cnt != SW'(STARVE_MAX)) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end

endmodule
